// File: rtl/cmp_link_pkg.sv
// Shared types, widths and helpers for the comparator operand link.
// Used by cmp_operand_sender, its link interface and link_timer.
package cmp_link_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int OPERAND_W   = 8;
    localparam int NUM_NIBBLES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_SETTLE
    } sender_state_t;

    typedef logic [NIBBLE_W-1:0]  nibble_t;
    typedef logic [OPERAND_W-1:0] operand_t;

    // Bits needed to hold a down-counter load value of max_val.
    function automatic int count_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Nibble k of the transfer word: k0/k1 come from A, k2/k3 from B.
    function automatic nibble_t nibble_at(input operand_t a, input operand_t b,
                                          input logic [1:0] k);
        logic [2*OPERAND_W-1:0] word;
        word = {b, a};
        return word[k*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/cmp_operand_sender_if.sv
// Nibble-strobed operand-load link between the sender and the comparator.
// The sender is the master; the comparator drives back its l/g/e result.
interface cmp_operand_sender_if;
    import cmp_link_pkg::*;

    nibble_t y;
    logic    pb1;
    logic    pb2;
    logic    pb3;
    logic    pb4;
    logic    l_in;
    logic    g_in;
    logic    e_in;

    modport master (
        output y, pb1, pb2, pb3, pb4,
        input  l_in, g_in, e_in
    );

    modport slave (
        input  y, pb1, pb2, pb3, pb4,
        output l_in, g_in, e_in
    );

endinterface

// File: rtl/link_timer.sv
// Loadable down-counter with a zero flag; times the strobe-high and settle
// intervals of cmp_operand_sender. Holds at zero until reloaded.
module link_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cmp_operand_sender.sv
// Sends two 8-bit operands to the comparator as four strobed nibbles, waits a
// settle interval and captures l/g/e. Define CMP_SENDER_CHECK_EN to build the
// one-hot result check driving `error`; otherwise `error` is tied low.
module cmp_operand_sender
    import cmp_link_pkg::*;
#(
    parameter int STROBE_HIGH = 2,
    parameter int SETTLE      = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  operand_t a_in,
    input  operand_t b_in,
    output logic     lt,
    output logic     gt,
    output logic     eq,
    output logic     busy,
    output logic     done,
    output logic     error,
    cmp_operand_sender_if.master link
);

    localparam int MAX_LOAD = ((STROBE_HIGH > SETTLE) ? STROBE_HIGH : SETTLE) - 1;
    localparam int TW       = count_width(MAX_LOAD);

    localparam logic [TW-1:0] STROBE_LOAD = TW'(STROBE_HIGH - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE - 1);
    localparam logic [1:0]    LAST_K      = 2'(NUM_NIBBLES - 1);

    sender_state_t              state;
    logic [1:0]                 k;
    operand_t                   a_q;
    operand_t                   b_q;
    nibble_t                    y_q;
    logic [NUM_NIBBLES-1:0]     pb_q;

    logic                       timer_load;
    logic [TW-1:0]              timer_val;
    logic                       timer_zero;
    logic                       accept;
    logic                       capture;

    assign accept  = (state == S_IDLE) && start;
    assign capture = (state == S_SETTLE) && timer_zero;

    // The timer is loaded on the same edge that enters STROBE or SETTLE,
    // so its first cycle in that state already shows the loaded count.
    always_comb begin
        // NOTE: defaults first so every path assigns these; no latch is inferred.
        timer_load = 1'b0;
        timer_val  = STROBE_LOAD;
        if (state == S_SETUP) begin
            timer_load = 1'b1;
        end else if ((state == S_HOLD) && (k == LAST_K)) begin
            timer_load = 1'b1;
            timer_val  = SETTLE_LOAD;
        end
    end

    link_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            pb_q  <= '0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        k     <= '0;
                        y_q   <= nibble_at(a_in, b_in, 2'd0);
                        busy  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    pb_q  <= NUM_NIBBLES'(1) << k;
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    if (timer_zero) begin
                        pb_q  <= '0;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (k == LAST_K) begin
                        state <= S_SETTLE;
                    end else begin
                        k     <= k + 2'd1;
                        y_q   <= nibble_at(a_q, b_q, k + 2'd1);
                        state <= S_SETUP;
                    end
                end
                S_SETTLE: begin
                    if (timer_zero) begin
                        lt    <= link.l_in;
                        gt    <= link.g_in;
                        eq    <= link.e_in;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    pb_q  <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CMP_SENDER_CHECK_EN
    // Sticky until the next accept; a capture overwrites it once per operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (capture) begin
            error <= !$onehot({link.l_in, link.g_in, link.e_in});
        end
    end
`else
    assign error = 1'b0;
`endif

    assign link.y   = y_q;
    assign link.pb1 = pb_q[0];
    assign link.pb2 = pb_q[1];
    assign link.pb3 = pb_q[2];
    assign link.pb4 = pb_q[3];

endmodule

// File: tb/tb_cmp_operand_sender.sv
// Self-checking bench: lane 0 uses default timing, lane 1 the minimum (1/1).
// A timeline model per lane predicts every output each cycle.
module tb_cmp_operand_sender;
    import cmp_link_pkg::*;

    localparam int NL = 2;

`ifdef CMP_SENDER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    function automatic int sh_of(input int l);
        return (l == 0) ? 2 : 1;
    endfunction

    function automatic int st_of(input int l);
        return (l == 0) ? 4 : 1;
    endfunction

    function automatic int n_of(input int l);
        return 4 * (sh_of(l) + 2) + st_of(l);
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       start   [NL];
    logic [7:0] a_in    [NL];
    logic [7:0] b_in    [NL];
    logic       fault   [NL];
    logic [3:0] y_w     [NL];
    logic [3:0] pb_w    [NL];
    logic [7:0] reg_a   [NL];
    logic [7:0] reg_b   [NL];
    logic       lt_w    [NL];
    logic       gt_w    [NL];
    logic       eq_w    [NL];
    logic       busy_w  [NL];
    logic       done_w  [NL];
    logic       err_w   [NL];

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;
    int done_cnt [NL];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        cmp_operand_sender_if link ();
        logic [7:0] ra;
        logic [7:0] rb;

        cmp_operand_sender #(
            .STROBE_HIGH (sh_of(i)),
            .SETTLE      (st_of(i))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .start (start[i]),
            .a_in  (a_in[i]),
            .b_in  (b_in[i]),
            .lt    (lt_w[i]),
            .gt    (gt_w[i]),
            .eq    (eq_w[i]),
            .busy  (busy_w[i]),
            .done  (done_w[i]),
            .error (err_w[i]),
            .link  (link)
        );

        // Pushbutton comparator: each register half loads on its strobe's rising edge.
        always @(posedge link.pb1) ra[3:0] <= link.y;
        always @(posedge link.pb2) ra[7:4] <= link.y;
        always @(posedge link.pb3) rb[3:0] <= link.y;
        always @(posedge link.pb4) rb[7:4] <= link.y;

        assign link.l_in = fault[i] ? 1'b1 : (ra < rb);
        assign link.g_in = fault[i] ? 1'b1 : (ra > rb);
        assign link.e_in = fault[i] ? 1'b0 : (ra == rb);
        assign y_w[i]    = link.y;
        assign pb_w[i]   = {link.pb4, link.pb3, link.pb2, link.pb1};
        assign reg_a[i]  = ra;
        assign reg_b[i]  = rb;
    end

    task automatic check(input string name, input int lane,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d at %0t: got %0h expected %0h", name, lane, $time, act, exp);
        end
    endtask

    // Timeline model: m_e = edges since the accept edge (-1: nothing since reset).
    int         m_e   [NL];
    logic [7:0] m_a   [NL];
    logic [7:0] m_b   [NL];
    logic       m_flt [NL];
    logic [3:0] m_y   [NL];
    logic       m_lt  [NL];
    logic       m_gt  [NL];
    logic       m_eq  [NL];
    logic       m_err [NL];

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            int p;
            int n;
            p = sh_of(l) + 2;
            n = n_of(l);
            if (reset) begin
                m_e[l]   = -1;
                m_y[l]   = 4'h0;
                m_lt[l]  = 1'b0;
                m_gt[l]  = 1'b0;
                m_eq[l]  = 1'b0;
                m_err[l] = 1'b0;
            end else begin
                if (start[l] && (m_e[l] < 0 || m_e[l] >= n)) begin
                    m_e[l]   = 0;
                    m_a[l]   = a_in[l];
                    m_b[l]   = b_in[l];
                    m_flt[l] = fault[l];
                    m_err[l] = 1'b0;
                end else if (m_e[l] >= 0 && m_e[l] <= n) begin
                    m_e[l]++;
                end
                if (m_e[l] >= 0 && m_e[l] < 4 * p && (m_e[l] % p) == 0)
                    m_y[l] = 4'(({m_b[l], m_a[l]} >> (4 * (m_e[l] / p))) & 16'hF);
                if (m_e[l] == n) begin
                    m_lt[l]  = m_flt[l] ? 1'b1 : (m_a[l] < m_b[l]);
                    m_gt[l]  = m_flt[l] ? 1'b1 : (m_a[l] > m_b[l]);
                    m_eq[l]  = m_flt[l] ? 1'b0 : (m_a[l] == m_b[l]);
                    m_err[l] = CHECK_EN && m_flt[l];
                end
            end
        end
    end

    function automatic logic [3:0] exp_pb(input int l, input int e);
        logic [3:0] r;
        int p;
        r = '0;
        p = sh_of(l) + 2;
        for (int kk = 0; kk < 4; kk++)
            if (e >= kk * p + 1 && e <= kk * p + sh_of(l)) r[kk] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) done_cnt[l] += int'(done_w[l]);
        if (cmp_on) begin
            for (int l = 0; l < NL; l++) begin
                check("busy",  l, busy_w[l], (m_e[l] >= 0 && m_e[l] < n_of(l)));
                check("done",  l, done_w[l], (m_e[l] == n_of(l)));
                check("y",     l, y_w[l],    m_y[l]);
                check("pb",    l, pb_w[l],   exp_pb(l, m_e[l]));
                check("lt",    l, lt_w[l],   m_lt[l]);
                check("gt",    l, gt_w[l],   m_gt[l]);
                check("eq",    l, eq_w[l],   m_eq[l]);
                check("error", l, err_w[l],  m_err[l]);
            end
        end
    end

    // Starts an operation at a negedge and returns in its done cycle.
    // poke >= 1 pulses a second start that many cycles after accept.
    task automatic run_op(input int l, input logic [7:0] a, input logic [7:0] b,
                          input logic flt, input int poke, output int lat);
        fault[l] = flt;
        a_in[l]  = a;
        b_in[l]  = b;
        start[l] = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done_w[l] && lat < 200) begin
            start[l] = (lat == poke);
            if (lat == poke) begin
                a_in[l] = 8'($urandom);
                b_in[l] = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start[l] = 1'b0;
        check("done_seen", l, done_w[l], 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int snap;
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            start[l] = 1'b0;
            a_in[l]  = '0;
            b_in[l]  = '0;
            fault[l] = 1'b0;
            done_cnt[l] = 0;
        end
        @(negedge clk);
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_y", 0, y_w[0], 0);
        check("rst_busy", 0, busy_w[0], 0);

        // Greater-than: nibble/strobe pairing lands A and B in the comparator.
        run_op(0, 8'h5A, 8'h3C, 1'b0, -1, lat);
        check("gt_latency", 0, lat, 20);
        check("gt_reg_a", 0, reg_a[0], 8'h5A);
        check("gt_reg_b", 0, reg_b[0], 8'h3C);
        check("gt_gt", 0, gt_w[0], 1);
        check("gt_lt", 0, lt_w[0], 0);

        // Equal, then back-to-back start in the done cycle for less-than.
        run_op(0, 8'hFF, 8'hFF, 1'b0, -1, lat);
        check("eq_eq", 0, eq_w[0], 1);
        run_op(0, 8'h00, 8'h01, 1'b0, -1, lat);
        check("b2b_latency", 0, lat, 20);
        check("b2b_lt", 0, lt_w[0], 1);

        // Start while busy is ignored.
        repeat (2) @(negedge clk);
        snap = done_cnt[0];
        run_op(0, 8'h96, 8'h69, 1'b0, 7, lat);
        repeat (30) @(negedge clk);
        check("busy_start_dones", 0, done_cnt[0] - snap, 1);
        check("busy_start_reg_a", 0, reg_a[0], 8'h96);
        check("busy_start_gt", 0, gt_w[0], 1);

        // Error check with a non-one-hot comparator answer, then cleared.
        run_op(0, 8'h12, 8'h34, 1'b1, -1, lat);
        check("err_at_done", 0, err_w[0], CHECK_EN);
        run_op(0, 8'h34, 8'h12, 1'b0, -1, lat);
        check("err_cleared", 0, err_w[0], 0);

        // Reset while pb2 is high.
        a_in[0] = 8'h33;
        b_in[0] = 8'h44;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!pb_w[0][1] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("pb2_seen", 0, pb_w[0][1], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_pb", 0, pb_w[0], 0);
        check("rst_mid_y", 0, y_w[0], 0);
        check("rst_mid_busy", 0, busy_w[0], 0);
        check("rst_mid_res", 0, {lt_w[0], gt_w[0], eq_w[0]}, 0);
        snap = done_cnt[0];
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 0, done_cnt[0] - snap, 0);

        // Minimum timing lane.
        run_op(1, 8'h80, 8'h7F, 1'b0, -1, lat);
        check("min_latency", 1, lat, 13);
        check("min_gt", 1, gt_w[1], 1);

        // Randomized operations on both lanes.
        for (int l = 0; l < NL; l++) begin
            for (int it = 0; it < 25; it++) begin
                int poke;
                ra = 8'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
                poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n_of(l) - 1)) : -1;
                run_op(l, ra, rb, ($urandom_range(0, 7) == 0), poke, lat);
                check("rand_latency", l, lat, n_of(l));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
